uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1-style UART receiver, optionally with a parity bit.
- Consumes a one-cycle oversample tick enable running at BAUD_RATE*OVERSAMPLE, derived from the team's baud-rate generation logic.
- Synchronises the serial line, validates the start bit, samples each data bit at mid-bit and checks the stop bit.
- Delivers each byte on a one-cycle valid strobe to the downstream FIFO/host logic.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first; legal 5..9
OVERSAMPLE, 16, tick pulses per bit period; power of two, >= 8
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
i_Rx_Tick  input  1  one-clk-wide oversample enable pulse at BAUD_RATE*OVERSAMPLE
i_Rx_Serial  input  1  asynchronous serial line, idle high
o_Rx_Data  output  DATA_BITS  last good received word
o_Rx_Valid  output  1  one-clk pulse; o_Rx_Data is new
o_Frame_Err  output  1  one-clk pulse; stop bit sampled low
o_Parity_Err  output  1  one-clk pulse; parity mismatch (tied 0 without the macro)
o_Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser flops go to 1; state goes to IDLE.
  - Tick counter, bit counter and shift register clear.
  - o_Rx_Data = 0; o_Rx_Valid, o_Frame_Err, o_Parity_Err, o_Busy = 0.
  - Reset mid-frame abandons the frame with no strobe.
- Input synchroniser:
  - 2-flop synchroniser on i_Rx_Serial.
  - All decisions use the synchronised line (rx_s); this adds 2 clk of latency.
- Counters:
  - Tick counter tc is $clog2(OVERSAMPLE) bits and advances only on i_Rx_Tick.
  - Bit counter is $clog2(DATA_BITS+1) bits.
- State IDLE:
  - On a tick with rx_s==0: go to START, tc=0.
- State START:
  - On each tick, tc++.
  - At tc==OVERSAMPLE/2-1 (mid start bit): if rx_s==0, go to DATA with tc=0 and bit count 0; else false start, return to IDLE with no strobe.
- State DATA:
  - On each tick, tc++.
  - At tc==OVERSAMPLE-1: shift rx_s into the MSB of the shift register (shift right), tc=0, bit count++.
  - After DATA_BITS samples, go to PARITY (macro defined) or STOP.
- State PARITY (macro only):
  - Same timing as a data bit; sample and store the parity bit, then go to STOP.
- State STOP, at tc==OVERSAMPLE-1:
  - rx_s==1: o_Rx_Data <= shift register; o_Rx_Valid pulses; o_Parity_Err pulses in the same cycle if parity mismatched; go to IDLE.
  - rx_s==0: o_Frame_Err pulses; o_Rx_Data holds its previous value; no valid strobe; go to WAIT_IDLE.
- State WAIT_IDLE (break or line-stuck recovery):
  - Stay until a tick with rx_s==1, then go to IDLE.
  - Prevents a held-low line from re-triggering frames.
- Strobes:
  - Asserted exactly one clk, in the cycle after the stop-bit sampling tick.
  - Never asserted together with a state other than the IDLE/WAIT_IDLE transition.
- Back-to-back frames:
  - A start bit may begin on the first tick after STOP returns to IDLE.
  - No idle gap is required between frames.
- i_Rx_Tick held high continuously is legal: the block advances one tick per clk.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is present.
  - Expected parity = XOR of data bits, XORed with PARITY_ODD.
  - On a mismatch with a good stop bit: o_Rx_Valid and o_Parity_Err pulse together and the data is still delivered.
  - On a framing error: only o_Frame_Err pulses.
- Undefined:
  - No PARITY state; frame is start + DATA_BITS + stop.
  - o_Parity_Err is constant 0.

Test Plan:
- Bench setup for all scenarios: defaults, i_Rx_Tick every 4 clk, so 1 bit = 64 clk.
1. Frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) -> single o_Rx_Valid pulse with o_Rx_Data=0xA5; o_Frame_Err=0; o_Busy falls in the same cycle as the strobe.
2. Line low for 3 ticks (12 clk), then high -> START aborts at mid-bit check; no strobes; o_Busy returns to 0; o_Rx_Data unchanged.
3. Frame 0x3C with stop bit 0, line then held low 20 bit times, then high, then frame 0x55 -> o_Frame_Err pulses once; o_Rx_Data keeps its prior value; no events while the line is held low; then o_Rx_Valid with 0x55.
4. Back-to-back frames 0x00 then 0xFF with zero idle between them -> two o_Rx_Valid pulses exactly 640 clk apart, data 0x00 then 0xFF.
5. reset pulsed during data bit 4 of frame 0x81, then a full frame 0x81 sent -> all outputs 0 immediately on reset; second frame produces o_Rx_Valid with 0x81.
6. With UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity bit 1 -> o_Rx_Valid, o_Parity_Err=0; 0x07 with parity bit 0 -> o_Rx_Valid and o_Parity_Err pulse together, data 0x07.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: tick/serial in, word and status strobes out.
// slave = the receiver, master = whatever drives the line and consumes the words.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Rx_Tick;
  logic                 i_Rx_Serial;
  logic [DATA_BITS-1:0] o_Rx_Data;
  logic                 o_Rx_Valid;
  logic                 o_Frame_Err;
  logic                 o_Parity_Err;
  logic                 o_Busy;

  modport slave (
    input  i_Rx_Tick, i_Rx_Serial,
    output o_Rx_Data, o_Rx_Valid, o_Frame_Err, o_Parity_Err, o_Busy
  );

  modport master (
    output i_Rx_Tick, i_Rx_Serial,
    input  o_Rx_Data, o_Rx_Valid, o_Frame_Err, o_Parity_Err, o_Busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, mid-bit sampling, stop check.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic    clk,
  input  logic    reset,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [TW-1:0]        tc, tc_n;
  logic [BW-1:0]        bc, bc_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 valid_q, valid_n;
  logic                 ferr_q, ferr_n;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic                 par, par_n;
  logic                 perr_q, perr_n;
`endif

  assign tick = bus.i_Rx_Tick;
  assign rx_s = sync[1];

  // Sync flops reset to the idle level so reset release cannot fake a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], bus.i_Rx_Serial};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tc      <= '0;
      bc      <= '0;
      sh      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par     <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      tc      <= tc_n;
      bc      <= bc_n;
      sh      <= sh_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par     <= par_n;
      perr_q  <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    tc_n    = tc;
    bc_n    = bc;
    sh_n    = sh;
    data_n  = data_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (tick && !rx_s) begin
          state_n = START;
          tc_n    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tc == TC_MID) begin
            // A low line that is gone by mid start bit is a glitch, not a frame.
            if (!rx_s) begin
              state_n = DATA;
              tc_n    = '0;
              bc_n    = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tc_n = tc + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tc == TC_END) begin
            sh_n = {rx_s, sh[DATA_BITS-1:1]};
            tc_n = '0;
            bc_n = bc + BW'(1);
            if (bc == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            tc_n = tc + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tc == TC_END) begin
            par_n   = rx_s;
            tc_n    = '0;
            state_n = STOP;
          end else begin
            tc_n = tc + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tc == TC_END) begin
            tc_n = '0;
            if (rx_s) begin
              data_n  = sh;
              valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_n  = ((^sh) ^ PAR_ODD) != par;
`endif
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_IDLE;
            end
          end else begin
            tc_n = tc + TW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line returns high so a break does not retrigger.
        if (tick && rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_Rx_Data   = data_q;
  assign bus.o_Rx_Valid  = valid_q;
  assign bus.o_Frame_Err = ferr_q;
  assign bus.o_Busy      = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.o_Parity_Err = perr_q;
`else
  assign bus.o_Parity_Err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: tick every 4 clk, 64 clk per bit, events checked in order.
module tb_uart_rx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
    logic       gap;
  } ev_t;

  ev_t        sbq[$];
  int         nvec = 0, nerr = 0;
  longint     cyc = 0, last_valid = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic par_of(logic [7:0] d);
    return ^d;
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(logic b);
    bus.i_Rx_Serial = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(logic [7:0] d, logic stop, logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) send_bit(1'b1);
`endif
    send_bit(stop);
  endtask

  task automatic push(logic ferr, logic [7:0] d, logic perr, logic gap);
    ev_t e;
    e.ferr = ferr; e.data = d; e.perr = perr; e.gap = gap;
    sbq.push_back(e);
  endtask

  initial begin
    bus.i_Rx_Tick = 1'b0;
    for (int tph = 0; ; tph = (tph + 1) % 4) begin
      @(negedge clk);
      bus.i_Rx_Tick = (tph == 0);
    end
  end

  // Output monitor: every strobe must match the head of the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.o_Rx_Valid || bus.o_Frame_Err)) begin
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("kind_ferr", bus.o_Frame_Err, e.ferr);
          chk("kind_valid", bus.o_Rx_Valid, !e.ferr);
          if (e.ferr) begin
            chk("data_hold", bus.o_Rx_Data, last_good);
            chk("ferr_no_perr", bus.o_Parity_Err, 0);
          end else begin
            chk("data", bus.o_Rx_Data, e.data);
            chk("perr", bus.o_Parity_Err, e.perr);
            chk("busy_fall", {prev_busy, bus.o_Busy}, 2'b10);
            if (e.gap) chk("gap", 32'(cyc - last_valid), 640);
            last_valid = cyc;
            last_good  = e.data;
          end
        end
      end
      if (!reset && bus.o_Parity_Err) chk("perr_with_valid", bus.o_Rx_Valid, 1);
      prev_busy = bus.o_Busy;
    end
  end

  initial begin
    reset = 1'b1;
    bus.i_Rx_Serial = 1'b1;
    idle(3);
    chk("rst_data", bus.o_Rx_Data, 0);
    chk("rst_valid", bus.o_Rx_Valid, 0);
    chk("rst_ferr", bus.o_Frame_Err, 0);
    chk("rst_perr", bus.o_Parity_Err, 0);
    chk("rst_busy", bus.o_Busy, 0);
    reset = 1'b0;
    idle(64);

    // single good frame
    push(1'b0, 8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, par_of(8'hA5));
    idle(128);
    chk("t1_busy", bus.o_Busy, 0);

    // short low glitch must abort at mid start bit
    bus.i_Rx_Serial = 1'b0;
    idle(12);
    bus.i_Rx_Serial = 1'b1;
    idle(128);
    chk("t2_busy", bus.o_Busy, 0);
    chk("t2_data", bus.o_Rx_Data, 8'hA5);
    chk("t2_sb", sbq.size(), 0);

    // framing error, line held low, recovery, good frame
    push(1'b1, 8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, par_of(8'h3C));
    idle(20 * 64);
    chk("t3_wait_busy", bus.o_Busy, 1);
    chk("t3_data_held", bus.o_Rx_Data, 8'hA5);
    bus.i_Rx_Serial = 1'b1;
    idle(64);
    chk("t3_idle", bus.o_Busy, 0);
    push(1'b0, 8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, par_of(8'h55));
    idle(128);

    // back-to-back frames, no idle gap
    push(1'b0, 8'h00, 1'b0, 1'b0);
    push(1'b0, 8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b1, par_of(8'h00));
    send_frame(8'hFF, 1'b1, par_of(8'hFF));
    idle(128);
    chk("t4_sb", sbq.size(), 0);

    // reset in the middle of data bit 4 of 0x81
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0);
    bus.i_Rx_Serial = 1'b0;
    idle(32);
    reset = 1'b1;
    #1;
    chk("t5_rst_data", bus.o_Rx_Data, 0);
    chk("t5_rst_valid", bus.o_Rx_Valid, 0);
    chk("t5_rst_ferr", bus.o_Frame_Err, 0);
    chk("t5_rst_busy", bus.o_Busy, 0);
    idle(2);
    bus.i_Rx_Serial = 1'b1;
    reset = 1'b0;
    last_good = 8'h00;
    idle(128);
    chk("t5_no_strobe", bus.o_Rx_Data, 0);
    push(1'b0, 8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, par_of(8'h81));
    idle(128);

`ifdef UART_RX_PARITY_EN
    push(1'b0, 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    push(1'b0, 8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(128);
`endif

    chk("sb_drained", sbq.size(), 0);
    chk("end_busy", bus.o_Busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
